// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port data RAM between two masters: port 0 (data bus)
//   and port 1 (debug/loader). One access is in flight at a time. The
//   req->ack latency is fixed at 3 cycles: IDLE (grant) -> ISSUE (strobe)
//   -> RESP (capture) -> ack pulse in the following IDLE cycle.
//
// Ports
//   i_clock, i_reset            rising-edge clock, asynchronous active-low reset
//   i_mN_req / i_mN_write       request (held until ack) and direction (1=write)
//   i_mN_address / _write_data  operands, captured once at grant
//   o_mN_read_data              read result, valid while o_mN_ack=1
//   o_mN_ack                    one-cycle completion pulse
//   o_ram_read_enable / o_ram_write_enable   one-cycle RAM strobes
//   o_ram_address / o_ram_write_data         RAM operands (hold between accesses)
//   i_ram_read_data             RAM data, valid the cycle after the read strobe
//   o_busy                      high while an access is in progress
module ram_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_m0_req,
  input  logic                  i_m0_write,
  input  logic [ADDR_WIDTH-1:0] i_m0_address,
  input  logic [DATA_WIDTH-1:0] i_m0_write_data,
  output logic [DATA_WIDTH-1:0] o_m0_read_data,
  output logic                  o_m0_ack,
  input  logic                  i_m1_req,
  input  logic                  i_m1_write,
  input  logic [ADDR_WIDTH-1:0] i_m1_address,
  input  logic [DATA_WIDTH-1:0] i_m1_write_data,
  output logic [DATA_WIDTH-1:0] o_m1_read_data,
  output logic                  o_m1_ack,
  output logic                  o_ram_read_enable,
  output logic                  o_ram_write_enable,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_write_data,
  input  logic [DATA_WIDTH-1:0] i_ram_read_data,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                r_state,          w_state_next;
  logic                  r_last_grant,     w_last_grant_next;
  logic                  r_grant,          w_grant_next;
  logic                  r_write,          w_write_next;
  logic [ADDR_WIDTH-1:0] r_ram_address,    w_ram_address_next;
  logic [DATA_WIDTH-1:0] r_ram_write_data, w_ram_write_data_next;
  logic                  r_ram_re,         w_ram_re_next;
  logic                  r_ram_we,         w_ram_we_next;
  logic                  r_m0_ack,         w_m0_ack_next;
  logic                  r_m1_ack,         w_m1_ack_next;
  logic [DATA_WIDTH-1:0] r_m0_read_data,   w_m0_read_data_next;
  logic [DATA_WIDTH-1:0] r_m1_read_data,   w_m1_read_data_next;
  logic                  r_busy,           w_busy_next;

  logic w_m0_eligible;
  logic w_m1_eligible;
  logic w_winner;

  // A master whose ack is currently high is completing; its still-high req
  // belongs to the finished access and must not start a second one.
  assign w_m0_eligible = i_m0_req & ~r_m0_ack;
  assign w_m1_eligible = i_m1_req & ~r_m1_ack;

  always_comb begin
    if (w_m0_eligible && w_m1_eligible) begin
      w_winner = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
    end else begin
      w_winner = w_m1_eligible;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_last_grant_next     = r_last_grant;
    w_grant_next          = r_grant;
    w_write_next          = r_write;
    w_ram_address_next    = r_ram_address;
    w_ram_write_data_next = r_ram_write_data;
    w_ram_re_next         = 1'b0;
    w_ram_we_next         = 1'b0;
    w_m0_ack_next         = 1'b0;
    w_m1_ack_next         = 1'b0;
    w_m0_read_data_next   = r_m0_read_data;
    w_m1_read_data_next   = r_m1_read_data;
    w_busy_next           = r_busy;

    unique case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (w_m0_eligible || w_m1_eligible) begin
          w_grant_next          = w_winner;
          w_last_grant_next     = w_winner;
          w_write_next          = w_winner ? i_m1_write      : i_m0_write;
          w_ram_address_next    = w_winner ? i_m1_address    : i_m0_address;
          w_ram_write_data_next = w_winner ? i_m1_write_data : i_m0_write_data;
          w_ram_we_next         = w_write_next;
          w_ram_re_next         = ~w_write_next;
          w_busy_next           = 1'b1;
          w_state_next          = ISSUE;
        end
      end
      ISSUE: begin
        w_busy_next  = 1'b1;
        w_state_next = RESP;
      end
      RESP: begin
        // Read data from the RAM is valid now; writes leave read_data alone.
        if (r_grant) begin
          w_m1_ack_next = 1'b1;
          if (!r_write) w_m1_read_data_next = i_ram_read_data;
        end else begin
          w_m0_ack_next = 1'b1;
          if (!r_write) w_m0_read_data_next = i_ram_read_data;
        end
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state          <= IDLE;
      r_last_grant     <= 1'b1;  // port 0 wins the first contention
      r_grant          <= 1'b0;
      r_write          <= 1'b0;
      r_ram_address    <= '0;
      r_ram_write_data <= '0;
      r_ram_re         <= 1'b0;
      r_ram_we         <= 1'b0;
      r_m0_ack         <= 1'b0;
      r_m1_ack         <= 1'b0;
      r_m0_read_data   <= '0;
      r_m1_read_data   <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_last_grant     <= w_last_grant_next;
      r_grant          <= w_grant_next;
      r_write          <= w_write_next;
      r_ram_address    <= w_ram_address_next;
      r_ram_write_data <= w_ram_write_data_next;
      r_ram_re         <= w_ram_re_next;
      r_ram_we         <= w_ram_we_next;
      r_m0_ack         <= w_m0_ack_next;
      r_m1_ack         <= w_m1_ack_next;
      r_m0_read_data   <= w_m0_read_data_next;
      r_m1_read_data   <= w_m1_read_data_next;
      r_busy           <= w_busy_next;
    end
  end

  assign o_m0_read_data     = r_m0_read_data;
  assign o_m0_ack           = r_m0_ack;
  assign o_m1_read_data     = r_m1_read_data;
  assign o_m1_ack           = r_m1_ack;
  assign o_ram_read_enable  = r_ram_re;
  assign o_ram_write_enable = r_ram_we;
  assign o_ram_address      = r_ram_address;
  assign o_ram_write_data   = r_ram_write_data;
  assign o_busy             = r_busy;

endmodule
